armleocpu_tlb_asid: RTL and testbench

Parametrised, ASID-tagged, set-associative TLB; successor to the current fixed 4-way TLB. Sits between the CPU fetch/LSU address path and the page-table walker: resolves a virtual page number plus ASID to a physical page number and access tag with one-cycle registered latency. Adds per-set round-robin replacement, global-page support and sequenced invalidation (all / by ASID / by address).

---
 rtl/armleocpu_tlb_pkg.sv | 35 +++
 rtl/armleocpu_tlb_asid_way.sv | 76 +++++++
 rtl/armleocpu_tlb_asid.sv | 221 ++++++++++++++++++++++
 tb/tb_armleocpu_tlb_asid.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/armleocpu_tlb_pkg.sv
// Shared types for the ASID-tagged TLB: command/invalidate encodings,
// access-tag bit positions and the invalidation sequencer states.
package armleocpu_tlb_pkg;

    typedef enum logic [1:0] {
        CMD_NONE       = 2'd0,
        CMD_RESOLVE    = 2'd1,
        CMD_WRITE      = 2'd2,
        CMD_INVALIDATE = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        INV_ALL  = 2'd0,
        INV_ASID = 2'd1,
        INV_VA   = 2'd2,
        INV_RSVD = 2'd3
    } inv_mode_t;

    localparam int unsigned AT_V = 0;
    localparam int unsigned AT_R = 1;
    localparam int unsigned AT_W = 2;
    localparam int unsigned AT_X = 3;
    localparam int unsigned AT_U = 4;
    localparam int unsigned AT_G = 5;
    localparam int unsigned AT_A = 6;
    localparam int unsigned AT_D = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WALK   = 2'd1,
        ST_VA_RD  = 2'd2,
        ST_VA_CMP = 2'd3
    } state_t;

endpackage

// File: rtl/armleocpu_tlb_asid_way.sv
// One TLB way: synchronous-read entry array, valid flops, and the three
// compares (lookup, ASID-invalidate, VA-invalidate) on the registered read.
module armleocpu_tlb_asid_way
    import armleocpu_tlb_pkg::*;
#(
    parameter int unsigned ENTRIES_W = 4,
    parameter int unsigned VIRT_W    = 20,
    parameter int unsigned PHYS_W    = 22,
    parameter int unsigned ASID_W    = 9
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ENTRIES_W-1:0]        rd_set,
    input  logic [VIRT_W-ENTRIES_W-1:0] cmp_tag,
    input  logic [ASID_W-1:0]           cmp_asid,
    output logic                        hit,
    output logic                        asid_hit,
    output logic                        tag_hit,
    output logic [7:0]                  rd_accesstag,
    output logic [PHYS_W-1:0]           rd_phys,
    input  logic                        wr_en,
    input  logic [ENTRIES_W-1:0]        wr_set,
    input  logic [VIRT_W-ENTRIES_W-1:0] wr_tag,
    input  logic [ASID_W-1:0]           wr_asid,
    input  logic [7:0]                  wr_accesstag,
    input  logic [PHYS_W-1:0]           wr_phys,
    output logic                        wr_set_valid,
    input  logic                        clear_all,
    input  logic                        clear_set_en,
    input  logic [ENTRIES_W-1:0]        clear_set
);
    localparam int unsigned SETS    = 1 << ENTRIES_W;
    localparam int unsigned TAG_W   = VIRT_W - ENTRIES_W;
    localparam int unsigned ENTRY_W = TAG_W + ASID_W + 8 + PHYS_W;

    logic [SETS-1:0]    valid;
    logic [ENTRY_W-1:0] mem [SETS];
    logic [ENTRY_W-1:0] rd_q;
    logic               rd_valid;
    logic [TAG_W-1:0]   q_tag;
    logic [ASID_W-1:0]  q_asid;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_set] <= {wr_tag, wr_asid, wr_accesstag, wr_phys};
        end
        rd_q <= mem[rd_set];
    end

    // The valid bit is captured with the read so a response reflects the
    // state at issue time, even if an invalidate lands the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= valid[rd_set];
            if (clear_all) begin
                valid <= '0;
            end else if (clear_set_en) begin
                valid[clear_set] <= 1'b0;
            end else if (wr_en) begin
                valid[wr_set] <= 1'b1;
            end
        end
    end

    assign {q_tag, q_asid, rd_accesstag, rd_phys} = rd_q;

    assign hit          = rd_valid && (q_tag == cmp_tag) &&
                          ((q_asid == cmp_asid) || rd_accesstag[AT_G]);
    assign asid_hit     = rd_valid && (q_asid == cmp_asid) && !rd_accesstag[AT_G];
    assign tag_hit      = rd_valid && (q_tag == cmp_tag);
    assign wr_set_valid = valid[wr_set];

endmodule

// File: rtl/armleocpu_tlb_asid.sv
// ASID-tagged set-associative TLB: one-cycle registered lookup, per-set
// round-robin replacement and sequenced invalidation (all / ASID / VA).
module armleocpu_tlb_asid
    import armleocpu_tlb_pkg::*;
#(
    parameter int unsigned ENTRIES_W = 4,
    parameter int unsigned WAYS_W    = 2,
    parameter int unsigned VIRT_W    = 20,
    parameter int unsigned PHYS_W    = 22,
    parameter int unsigned ASID_W    = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          cmd,
    input  logic [1:0]          inv_mode,
    input  logic [VIRT_W-1:0]   virtual_address,
    input  logic [ASID_W-1:0]   asid,
    input  logic [7:0]          accesstag_w,
    input  logic [PHYS_W-1:0]   phys_w,
    output logic                busy,
    output logic                done,
    output logic                miss,
    output logic [WAYS_W-1:0]   hit_way,
    output logic [7:0]          accesstag_r,
    output logic [PHYS_W-1:0]   phys_r
);
    localparam int unsigned SETS  = 1 << ENTRIES_W;
    localparam int unsigned WAYS  = 1 << WAYS_W;
    localparam int unsigned TAG_W = VIRT_W - ENTRIES_W;

    cmd_t                 cmd_e;
    inv_mode_t            mode_e;
    state_t               state;
    logic                 idle;
    logic                 accept_resolve;
    logic                 accept_write;
    logic                 accept_inv;
    logic                 clear_all;
    logic [ENTRIES_W-1:0] rd_set;
    logic [ENTRIES_W-1:0] wr_set;
    logic [ENTRIES_W-1:0] set_cnt;
    logic [ENTRIES_W-1:0] cmp_set;
    logic [ENTRIES_W-1:0] va_set;
    logic                 walk_rd_done;
    logic                 walk_cmp;
    logic [TAG_W-1:0]     key_tag;
    logic [ASID_W-1:0]    key_asid;
    logic [WAYS_W-1:0]    victim [SETS];
    logic [WAYS_W-1:0]    wr_target;
    logic                 free_found;
    logic [WAYS_W-1:0]    hit_idx;
    logic                 any_hit;

    logic [WAYS-1:0]      way_hit;
    logic [WAYS-1:0]      way_asid_hit;
    logic [WAYS-1:0]      way_tag_hit;
    logic [WAYS-1:0]      way_set_valid;
    logic [WAYS-1:0]      way_clear;
    logic [7:0]           way_accesstag [WAYS];
    logic [PHYS_W-1:0]    way_phys [WAYS];

    assign cmd_e          = cmd_t'(cmd);
    assign mode_e         = inv_mode_t'(inv_mode);
    assign idle           = (state == ST_IDLE);
    assign accept_resolve = idle && (cmd_e == CMD_RESOLVE);
    assign accept_write   = idle && (cmd_e == CMD_WRITE);
    assign accept_inv     = idle && (cmd_e == CMD_INVALIDATE);
    assign clear_all      = accept_inv && ((mode_e == INV_ALL) || (mode_e == INV_RSVD));
    assign wr_set         = virtual_address[ENTRIES_W-1:0];

    always_comb begin
        rd_set = virtual_address[ENTRIES_W-1:0];
        case (state)
            ST_WALK:  rd_set = set_cnt;
            ST_VA_RD: rd_set = va_set;
            default:  ;
        endcase
    end

    // Lowest invalid way first; only a full set consumes the victim pointer.
    always_comb begin
        free_found = 1'b0;
        wr_target  = victim[wr_set];
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!free_found && !way_set_valid[w]) begin
                free_found = 1'b1;
                wr_target  = WAYS_W'(w);
            end
        end
    end

    always_comb begin
        for (int unsigned w = 0; w < WAYS; w++) begin
            way_clear[w] = ((state == ST_WALK) && walk_cmp && way_asid_hit[w]) ||
                           ((state == ST_VA_CMP) && way_tag_hit[w]);
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        armleocpu_tlb_asid_way #(
            .ENTRIES_W (ENTRIES_W),
            .VIRT_W    (VIRT_W),
            .PHYS_W    (PHYS_W),
            .ASID_W    (ASID_W)
        ) u_way (
            .clk          (clk),
            .rst_n        (rst_n),
            .rd_set       (rd_set),
            .cmp_tag      (key_tag),
            .cmp_asid     (key_asid),
            .hit          (way_hit[w]),
            .asid_hit     (way_asid_hit[w]),
            .tag_hit      (way_tag_hit[w]),
            .rd_accesstag (way_accesstag[w]),
            .rd_phys      (way_phys[w]),
            .wr_en        (accept_write && (wr_target == WAYS_W'(w))),
            .wr_set       (wr_set),
            .wr_tag       (virtual_address[VIRT_W-1:ENTRIES_W]),
            .wr_asid      (asid),
            .wr_accesstag (accesstag_w),
            .wr_phys      (phys_w),
            .wr_set_valid (way_set_valid[w]),
            .clear_all    (clear_all),
            .clear_set_en (way_clear[w]),
            .clear_set    (cmp_set)
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                victim[s] <= '0;
            end
        end else if (accept_write && !free_found) begin
            victim[wr_set] <= victim[wr_set] + WAYS_W'(1);
        end
    end

    // The walk issues one read per set; each compare/clear trails its read
    // by a cycle, so one extra cycle after the last read finishes the sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            set_cnt      <= '0;
            walk_rd_done <= 1'b0;
            walk_cmp     <= 1'b0;
            cmp_set      <= '0;
            va_set       <= '0;
            key_tag      <= '0;
            key_asid     <= '0;
        end else begin
            done    <= 1'b0;
            cmp_set <= rd_set;
            case (state)
                ST_IDLE: begin
                    done <= accept_resolve;
                    if (accept_resolve || accept_inv) begin
                        key_tag  <= virtual_address[VIRT_W-1:ENTRIES_W];
                        key_asid <= asid;
                        va_set   <= virtual_address[ENTRIES_W-1:0];
                    end
                    if (accept_inv) begin
                        case (mode_e)
                            INV_ASID: begin
                                state        <= ST_WALK;
                                busy         <= 1'b1;
                                set_cnt      <= '0;
                                walk_rd_done <= 1'b0;
                                walk_cmp     <= 1'b0;
                            end
                            INV_VA: begin
                                state <= ST_VA_RD;
                                busy  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_WALK: begin
                    walk_cmp <= !walk_rd_done;
                    if (walk_rd_done) begin
                        state        <= ST_IDLE;
                        busy         <= 1'b0;
                        walk_rd_done <= 1'b0;
                    end else begin
                        set_cnt <= set_cnt + 1'b1;
                        if (set_cnt == '1) begin
                            walk_rd_done <= 1'b1;
                        end
                    end
                end
                ST_VA_RD: begin
                    state <= ST_VA_CMP;
                end
                ST_VA_CMP: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        any_hit = 1'b0;
        hit_idx = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!any_hit && way_hit[w]) begin
                any_hit = 1'b1;
                hit_idx = WAYS_W'(w);
            end
        end
    end

    assign miss        = done && !any_hit;
    assign hit_way     = (done && any_hit) ? hit_idx : '0;
    assign accesstag_r = (done && any_hit) ? way_accesstag[hit_idx] : '0;
    assign phys_r      = (done && any_hit) ? way_phys[hit_idx] : '0;

endmodule

// File: tb/tb_armleocpu_tlb_asid.sv
// Scoreboard bench for armleocpu_tlb_asid: a behavioural TLB model predicts
// each RESOLVE response, queued at issue and compared when done pulses.
module tb_armleocpu_tlb_asid;
    import armleocpu_tlb_pkg::*;

    localparam int unsigned SETS = 16;
    localparam int unsigned WAYS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cmd;
    logic [1:0]  inv_mode;
    logic [19:0] virtual_address;
    logic [8:0]  asid;
    logic [7:0]  accesstag_w;
    logic [21:0] phys_w;
    logic        busy;
    logic        done;
    logic        miss;
    logic [1:0]  hit_way;
    logic [7:0]  accesstag_r;
    logic [21:0] phys_r;

    always #5 clk = ~clk;

    armleocpu_tlb_asid #(
        .ENTRIES_W (4),
        .WAYS_W    (2),
        .VIRT_W    (20),
        .PHYS_W    (22),
        .ASID_W    (9)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd             (cmd),
        .inv_mode        (inv_mode),
        .virtual_address (virtual_address),
        .asid            (asid),
        .accesstag_w     (accesstag_w),
        .phys_w          (phys_w),
        .busy            (busy),
        .done            (done),
        .miss            (miss),
        .hit_way         (hit_way),
        .accesstag_r     (accesstag_r),
        .phys_r          (phys_r)
    );

    typedef struct packed {
        logic        miss;
        logic [1:0]  way;
        logic [7:0]  at;
        logic [21:0] phys;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;
    int   busy_cycles = 0;

    logic        m_v   [SETS][WAYS];
    logic [19:0] m_vpn [SETS][WAYS];
    logic [8:0]  m_as  [SETS][WAYS];
    logic [7:0]  m_at  [SETS][WAYS];
    logic [21:0] m_ph  [SETS][WAYS];
    logic [1:0]  m_vic [SETS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t m_lookup(input logic [19:0] va, input logic [8:0] as);
        exp_t        r;
        int unsigned s;
        r      = '0;
        r.miss = 1'b1;
        s      = int'(va[3:0]);
        for (int w = 0; w < int'(WAYS); w++) begin
            if (r.miss && m_v[s][w] && (m_vpn[s][w] == va) &&
                ((m_as[s][w] == as) || m_at[s][w][5])) begin
                r.miss = 1'b0;
                r.way  = w[1:0];
                r.at   = m_at[s][w];
                r.phys = m_ph[s][w];
            end
        end
        return r;
    endfunction

    task automatic m_clear();
        for (int s = 0; s < int'(SETS); s++) begin
            m_vic[s] = 2'd0;
            for (int w = 0; w < int'(WAYS); w++) m_v[s][w] = 1'b0;
        end
    endtask

    task automatic m_write(input logic [19:0] va, input logic [8:0] as,
                           input logic [7:0] at, input logic [21:0] ph);
        int   s;
        int   t;
        exp_t r;
        s = int'(va[3:0]);
        t = -1;
        r = m_lookup(va, as);
        if (!r.miss) begin
            $display("FAIL wr_precondition: va 0x%0h asid %0d already maps", va, as);
            $fatal(1);
        end
        for (int w = 0; w < int'(WAYS); w++) if (t < 0 && !m_v[s][w]) t = w;
        if (t < 0) begin
            t = int'(m_vic[s]);
            m_vic[s] = m_vic[s] + 2'd1;
        end
        m_v[s][t] = 1'b1; m_vpn[s][t] = va; m_as[s][t] = as; m_at[s][t] = at; m_ph[s][t] = ph;
    endtask

    task automatic m_inv(input logic [1:0] mode, input logic [19:0] va, input logic [8:0] as);
        for (int s = 0; s < int'(SETS); s++) begin
            for (int w = 0; w < int'(WAYS); w++) begin
                if (mode == INV_ASID) begin
                    if (m_as[s][w] == as && !m_at[s][w][5]) m_v[s][w] = 1'b0;
                end else if (mode == INV_VA) begin
                    if (m_vpn[s][w] == va) m_v[s][w] = 1'b0;
                end else begin
                    m_v[s][w] = 1'b0;
                end
            end
        end
    endtask

    // Advance to the next falling edge and score whatever the DUT produced.
    task automatic tick();
        @(negedge clk);
        if (busy) busy_cycles++;
        if (done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("miss",        32'(miss),        32'(e.miss));
                check("hit_way",     32'(hit_way),     32'(e.way));
                check("accesstag_r", 32'(accesstag_r), 32'(e.at));
                check("phys_r",      32'(phys_r),      32'(e.phys));
            end
        end
    endtask

    task automatic put(input logic [1:0] c, input logic [1:0] m, input logic [19:0] va,
                       input logic [8:0] as, input logic [7:0] at, input logic [21:0] ph);
        cmd = c; inv_mode = m; virtual_address = va; asid = as; accesstag_w = at; phys_w = ph;
        case (c)
            CMD_RESOLVE:    exp_q.push_back(m_lookup(va, as));
            CMD_WRITE:      m_write(va, as, at, ph);
            CMD_INVALIDATE: m_inv(m, va, as);
            default: ;
        endcase
        tick();
        cmd = CMD_NONE;
    endtask

    task automatic resolve(input logic [19:0] va, input logic [8:0] as);
        put(CMD_RESOLVE, 2'd0, va, as, 8'h00, 22'h0);
    endtask

    task automatic write(input logic [19:0] va, input logic [8:0] as,
                         input logic [7:0] at, input logic [21:0] ph);
        put(CMD_WRITE, 2'd0, va, as, at, ph);
    endtask

    task automatic inval(input logic [1:0] mode, input logic [19:0] va, input logic [8:0] as);
        put(CMD_INVALIDATE, mode, va, as, 8'h00, 22'h0);
    endtask

    // A command offered while busy must be dropped, so the model is left alone.
    task automatic put_busy(input logic [1:0] c, input logic [19:0] va, input logic [8:0] as);
        check("busy_high", 32'(busy), 32'd1);
        cmd = c; inv_mode = 2'd0; virtual_address = va; asid = as;
        accesstag_w = 8'h0F; phys_w = 22'h3FFFF;
        tick();
        cmd = CMD_NONE;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        if (busy) check({tag, "_busy_timeout"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; cmd = CMD_NONE; inv_mode = 2'd0; virtual_address = '0;
        asid = '0; accesstag_w = '0; phys_w = '0;
        m_clear();
        repeat (3) tick();
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_done",        32'(done),        32'd0);
        check("rst_miss",        32'(miss),        32'd0);
        check("rst_hit_way",     32'(hit_way),     32'd0);
        check("rst_accesstag_r", 32'(accesstag_r), 32'd0);
        check("rst_phys_r",      32'(phys_r),      32'd0);
        rst_n = 1'b1;
        tick();

        resolve(20'h12345, 9'd1);
        write(20'h00013, 9'd5, 8'h0F, 22'h2ABCD);
        resolve(20'h00013, 9'd5);
        resolve(20'h00013, 9'd6);

        inval(INV_ALL, 20'h0, 9'd0);
        check("inv_all_busy", 32'(busy), 32'd0);
        resolve(20'h00013, 9'd5);

        for (int i = 0; i < 5; i++) begin
            write(20'h00003 + 20'(i * 16), 9'd3, 8'h0B, 22'h00100 + 22'(i));
        end
        resolve(20'h00003, 9'd3);
        resolve(20'h00043, 9'd3);
        resolve(20'h00013, 9'd3);
        write(20'h00053, 9'd3, 8'h07, 22'h00155);
        resolve(20'h00053, 9'd3);
        resolve(20'h00013, 9'd3);

        write(20'h00105, 9'd2, 8'h21, 22'h11111);
        write(20'h00205, 9'd2, 8'h0F, 22'h22222);
        write(20'h00305, 9'd4, 8'h07, 22'h33333);
        busy_cycles = 0;
        resolve(20'h00205, 9'd2);
        inval(INV_ASID, 20'h0, 9'd2);
        put_busy(CMD_RESOLVE, 20'h00205, 9'd2);
        wait_idle("asid");
        check("asid_busy_len", 32'(busy_cycles), 32'd17);
        resolve(20'h00105, 9'd7);
        resolve(20'h00205, 9'd2);
        resolve(20'h00305, 9'd4);
        resolve(20'h00305, 9'd5);
        resolve(20'h00043, 9'd3);

        write(20'h00013, 9'd8, 8'h0F, 22'h0AAAA);
        write(20'h00013, 9'd9, 8'h21, 22'h0BBBB);
        resolve(20'h00013, 9'd9);
        busy_cycles = 0;
        inval(INV_VA, 20'h00013, 9'd0);
        put_busy(CMD_WRITE, 20'h00093, 9'd3);
        wait_idle("va");
        check("va_busy_len", 32'(busy_cycles), 32'd2);
        resolve(20'h00013, 9'd8);
        resolve(20'h00013, 9'd9);
        resolve(20'h00043, 9'd3);
        resolve(20'h00053, 9'd3);
        resolve(20'h00093, 9'd3);
        write(20'h00063, 9'd3, 8'h0F, 22'h00663);
        resolve(20'h00063, 9'd3);
        write(20'h00073, 9'd3, 8'h0F, 22'h00773);
        write(20'h00083, 9'd3, 8'h0F, 22'h00883);
        resolve(20'h00083, 9'd3);
        resolve(20'h00043, 9'd3);

        inval(INV_ASID, 20'h0, 9'd3);
        repeat (4) tick();
        check("walk_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check("midwalk_rst_busy", 32'(busy), 32'd0);
        check("midwalk_rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        m_clear();
        resolve(20'h00063, 9'd3);
        resolve(20'h00105, 9'd7);
        resolve(20'h00305, 9'd4);
        resolve(20'h00083, 9'd3);
        write(20'h00093, 9'd3, 8'h0F, 22'h00993);
        resolve(20'h00093, 9'd3);

        cmd = CMD_NONE;
        repeat (2) tick();
        check("pending_responses", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
